bsort_ctrl: RTL and testbench

BSORT_CTRL -- requirements
Module: bsort_ctrl

---
 rtl/bsort_pkg.sv | 17 +
 rtl/bsort_cmp.sv | 13 +
 rtl/bsort_ctrl.sv | 144 ++++++++++++++
 tb/tb_bsort_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bsort_pkg.sv
// Shared constants and FSM state encoding for the bubble-sort controller
// and the register file it drives.
package bsort_pkg;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(N);

  // State encoding kept as plain constants so older tools can share it.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LOAD = 3'd1;
  localparam state_t S_CMP  = 3'd2;
  localparam state_t S_SWP  = 3'd3;
  localparam state_t S_FIN  = 3'd4;

endpackage

// File: rtl/bsort_cmp.sv
// Swap decision for one compare step: swap only when A is strictly
// greater than B (unsigned), so equal elements are never rewritten.
module bsort_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              swap_o
);

  assign swap_o = (a_i > b_i);

endmodule

// File: rtl/bsort_ctrl.sv
// Bubble-sort controller for an external dual-port register file.
// Loads N elements through the shift-load port, then runs an ascending
// bubble sort with early exit on a pass that makes no swap.
module bsort_ctrl #(
  parameter int DATA_W = bsort_pkg::DATA_W,
  parameter int N      = bsort_pkg::N,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] Aout,
  input  logic [DATA_W-1:0] Bout,
  output logic              qin,
  output logic [IDX_W-1:0]  AIndex,
  output logic [IDX_W-1:0]  BIndex,
  output logic              w_en,
  output logic [DATA_W-1:0] DinA,
  output logic [DATA_W-1:0] DinB,
  output logic              busy,
  output logic              done
);

  import bsort_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              swap_q, swap_d;
  logic              swapped_q, swapped_d;
  logic              cmp_swap;

  bsort_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a_i    (Aout),
    .b_i    (Bout),
    .swap_o (cmp_swap)
  );

  // Next-state logic: load counter, outer/inner loop indices, pass swap flag.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    swap_d     = swap_q;
    swapped_d  = swapped_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == LAST) begin
          state_d   = S_CMP;
          i_d       = LAST;
          j_d       = '0;
          swapped_d = 1'b0;
        end else begin
          load_cnt_d = load_cnt_q + ONE;
        end
      end
      S_CMP: begin
        a_d     = Aout;
        b_d     = Bout;
        swap_d  = cmp_swap;
        state_d = S_SWP;
      end
      S_SWP: begin
        // The flag for this pass includes the swap being written now.
        swapped_d = swapped_q | swap_q;
        if (j_q == i_q - ONE) begin
          if (!(swapped_q | swap_q) || (i_q == ONE)) begin
            state_d = S_FIN;
          end else begin
            i_d       = i_q - ONE;
            j_d       = '0;
            swapped_d = 1'b0;
            state_d   = S_CMP;
          end
        end else begin
          j_d     = j_q + ONE;
          state_d = S_CMP;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      swap_q     <= 1'b0;
      swapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      swap_q     <= swap_d;
      swapped_q  <= swapped_d;
    end
  end

  // Outputs decoded from registered state; idle values are all zero.
  always_comb begin
    qin    = (state_q == S_LOAD);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_FIN);
    AIndex = '0;
    BIndex = '0;
    w_en   = 1'b0;
    DinA   = '0;
    DinB   = '0;
    if (state_q == S_CMP || state_q == S_SWP) begin
      AIndex = j_q;
      BIndex = j_q + ONE;
    end
    if (state_q == S_SWP) begin
      w_en = swap_q;
      DinA = b_q;
      DinB = a_q;
    end
  end

endmodule

// File: tb/tb_bsort_ctrl.sv
// Bench for bsort_ctrl: behavioural register file, directed table,
// multi-cycle corner sequences and randomized runs against a model.
module tb_bsort_ctrl;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int IW  = 3;

  typedef logic [DW-1:0] arr_t [N];

  typedef struct {
    arr_t din;
    arr_t exp_s;
    int   exp_wr;
    int   exp_lat;
    int   inject;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] Aout, Bout;
  logic          qin, w_en, busy, done;
  logic [IW-1:0] AIndex, BIndex;
  logic [DW-1:0] DinA, DinB;

  bsort_ctrl #(.DATA_W(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .Aout(Aout), .Bout(Bout),
    .qin(qin), .AIndex(AIndex), .BIndex(BIndex), .w_en(w_en),
    .DinA(DinA), .DinB(DinB), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // register file model
  arr_t mem;
  arr_t load_buf;
  int   ld_k, wr_cnt, bad_wr, overlap, idle_bad;
  int   checks = 0, failures = 0;

  assign Aout = mem[AIndex];
  assign Bout = mem[BIndex];

  initial begin
    for (int k = 0; k < N; k++) mem[k] = '0;
    ld_k = 0; wr_cnt = 0; bad_wr = 0; overlap = 0; idle_bad = 0;
  end

  always @(posedge clk) begin
    if (qin && w_en) overlap++;
    if (w_en) begin
      wr_cnt++;
      if (!(mem[AIndex] > mem[BIndex]) || DinA != mem[BIndex] || DinB != mem[AIndex]) bad_wr++;
      mem[AIndex] <= DinA;
      mem[BIndex] <= DinB;
    end
    if (qin) begin
      for (int k = 0; k < N - 1; k++) mem[k] <= mem[k+1];
      mem[N-1] <= (ld_k < N) ? load_buf[ld_k] : '0;
      ld_k++;
    end
  end

  always @(posedge clk) begin
    assert (!(qin && w_en)) else $error("qin and w_en high together");
  end

  always @(negedge clk) begin
    if (!busy && ({AIndex, BIndex, DinA, DinB, w_en, qin, done} != '0)) idle_bad++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input arr_t a);
    logic [63:0] p = '0;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = a[k];
    return p;
  endfunction

  // Reference: sorted contents, swap count = inversion count, and latency
  // from the number of passes (largest count of bigger elements before any
  // element, plus one clean pass to notice, capped at N-1 passes).
  function automatic void model(input arr_t d, output arr_t s, output int inv, output int lat);
    int maxk = 0, passes, comps = 0;
    s = d;
    for (int a = 1; a < N; a++)
      for (int b = a; b > 0 && s[b-1] > s[b]; b--) begin
        logic [DW-1:0] t = s[b]; s[b] = s[b-1]; s[b-1] = t;
      end
    inv = 0;
    for (int a = 0; a < N; a++) begin
      int bigger = 0;
      for (int b = 0; b < a; b++) if (d[b] > d[a]) bigger++;
      inv += bigger;
      if (bigger > maxk) maxk = bigger;
    end
    passes = (maxk + 1 < N - 1) ? maxk + 1 : N - 1;
    for (int p = 0; p < passes; p++) comps += N - 1 - p;
    lat = 1 + N + 2 * comps + 1;
  endfunction

  // Run one sort from IDLE; optional extra start pulse at cycle 'inject'.
  task automatic run_sort(input string nm, input vec_t v);
    int  n = 1, busy_lo = 0, extra = 0;
    bit  got = 0;
    load_buf = v.din; ld_k = 0; wr_cnt = 0; bad_wr = 0;
    start = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      n++;
      start = (n == v.inject);
      if (done) got = 1;
      else if (!busy) busy_lo++;
    end
    start = 1'b0;
    chk({nm, "/done_seen"}, 64'(got), 64'd1);
    chk({nm, "/latency"}, 64'(n), 64'(v.exp_lat));
    @(negedge clk);
    chk({nm, "/done_1cyc"}, 64'({done, busy}), 64'd0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk({nm, "/no_restart"}, 64'(extra), 64'd0);
    chk({nm, "/busy_held"}, 64'(busy_lo), 64'd0);
    chk({nm, "/writes"}, 64'(wr_cnt), 64'(v.exp_wr));
    chk({nm, "/write_ok"}, 64'(bad_wr), 64'd0);
    chk({nm, "/contents"}, pack(mem), pack(v.exp_s));
  endtask

  vec_t tbl [4];

  initial begin
    vec_t v;
    int   inv, lat;
    bit   hit;

    tbl[0] = '{din: '{1,2,3,4,5,6,7,8}, exp_s: '{1,2,3,4,5,6,7,8}, exp_wr: 0,  exp_lat: 24, inject: -1};
    tbl[1] = '{din: '{8,7,6,5,4,3,2,1}, exp_s: '{1,2,3,4,5,6,7,8}, exp_wr: 28, exp_lat: 66, inject: -1};
    tbl[2] = '{din: '{5,5,3,3,9,0,9,1}, exp_s: '{0,1,3,3,5,5,9,9}, exp_wr: 15, exp_lat: 66, inject: -1};
    tbl[3] = '{din: '{8,7,6,5,4,3,2,1}, exp_s: '{1,2,3,4,5,6,7,8}, exp_wr: 28, exp_lat: 66, inject: 12};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset/outputs", 64'({qin, w_en, AIndex, BIndex, DinA, DinB, busy, done}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle/outputs", 64'({qin, w_en, AIndex, BIndex, DinA, DinB, busy, done}), 64'd0);

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_vs_start", 64'({busy, qin}), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    foreach (tbl[t]) run_sort($sformatf("dir%0d", t), tbl[t]);

    // reset in the middle of a swap
    load_buf = '{8,7,6,5,4,3,2,1}; ld_k = 0;
    start = 1'b1;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (w_en) hit = 1;
    end
    chk("midswp/reached", 64'(hit), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midswp/outputs", 64'({qin, w_en, AIndex, BIndex, DinA, DinB, busy, done}), 64'd0);
    rst = 1'b0;
    hit = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) hit = 1;
    end
    chk("midswp/no_done", 64'(hit), 64'd0);
    v.din = '{4,1,7,1,0,8,2,6}; v.inject = -1;
    model(v.din, v.exp_s, v.exp_wr, v.exp_lat);
    run_sort("midswp/resort", v);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++)
        v.din[k] = (r % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(0, 255));
      v.inject = -1;
      model(v.din, v.exp_s, v.exp_wr, v.exp_lat);
      run_sort($sformatf("rnd%0d", r), v);
    end

    chk("qin_wen_overlap", 64'(overlap), 64'd0);
    chk("idle_outputs_zero", 64'(idle_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
